// File: rtl/zorro_ram_autoconfig_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : zorro_ram_autoconfig_multi                                       |
// | Brief   : Zorro II autoconfig + RAM decode for a chain of RAM boards,      |
// |           with registered DTACK generation.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module zorro_ram_autoconfig_multi #(
  parameter int          NUM_BOARDS = 2,
  parameter logic [2:0]  SIZE_CODE  = 3'b110,
  parameter logic [7:0]  PRODUCT    = 8'hEF,
  parameter logic [15:0] MFG        = 16'h4001,
  parameter logic [3:0]  ER_FLAGS   = 4'hC,
  parameter int          DTACK_WAIT = 0
) (
  input  logic                  CLK,
  input  logic                  _RST,
  input  logic [7:0]            AH,
  input  logic [5:0]            AL,
  input  logic [3:0]            D_i,
  input  logic                  _AS,
  input  logic                  _UDS,
  input  logic                  RW,
  input  logic                  _configin,
  output logic                  _configout,
  output logic [3:0]            D_o,
  output logic                  config_oe,
  output logic                  DTACK,
  output logic [NUM_BOARDS-1:0] ramce
);

  localparam int             CW     = $clog2(NUM_BOARDS + 1);
  localparam logic [CW-1:0]  c_NB   = CW'(NUM_BOARDS);
  localparam logic [2:0]     c_WAIT = 3'(DTACK_WAIT);
  // Address bits A23..A16 that take part in the RAM compare for each board size
  localparam logic [7:0]     c_MASK = (SIZE_CODE == 3'b100) ? 8'hF8 :
                                      (SIZE_CODE == 3'b101) ? 8'hF0 :
                                      (SIZE_CODE == 3'b110) ? 8'hE0 : 8'hC0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } dt_state_t;

  logic                  r_as_s1, r_as_s2;
  logic                  r_uds_s1, r_uds_s2, r_uds_s3;
  logic [CW-1:0]         r_cur;
  logic [NUM_BOARDS-1:0] r_conf;
  logic [7:0]            r_base [NUM_BOARDS];
  dt_state_t             r_dt_state;
  logic [2:0]            r_cnt;

  logic                  w_ac_acc;
  logic                  w_ws;
  logic                  w_chain;
  logic [7:0]            w_prod;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_as_s1  <= 1'b1;
      r_as_s2  <= 1'b1;
      r_uds_s1 <= 1'b1;
      r_uds_s2 <= 1'b1;
      r_uds_s3 <= 1'b1;
    end else begin
      r_as_s1  <= _AS;
      r_as_s2  <= r_as_s1;
      r_uds_s1 <= _UDS;
      r_uds_s2 <= r_uds_s1;
      r_uds_s3 <= r_uds_s2;
    end
  end

  assign w_ac_acc   = (AH == 8'hE8) && (r_cur < c_NB) && !_configin && !_AS;
  assign w_ws       = r_uds_s3 && !r_uds_s2 && !RW;
  assign config_oe  = w_ac_acc && RW && _RST;
  assign _configout = !(r_cur == c_NB);

  // A shut-up board is simply one that cur has passed without being configured
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_cur  <= '0;
      r_conf <= '0;
      for (int i = 0; i < NUM_BOARDS; i++) r_base[i] <= 8'h00;
    end else if (w_ws && w_ac_acc) begin
      for (int i = 0; i < NUM_BOARDS; i++) begin
        if (r_cur == CW'(i)) begin
          case (AL)
            6'h24: begin
              r_base[i][7:4] <= D_i;
              r_conf[i]      <= 1'b1;
            end
            6'h25:   r_base[i][3:0] <= D_i;
            default: ;
          endcase
        end
      end
      if (AL == 6'h24 || AL == 6'h26) r_cur <= r_cur + CW'(1);
    end
  end

  assign w_prod  = PRODUCT + 8'(r_cur);
  assign w_chain = (r_cur != c_NB - CW'(1));

  always_comb begin
    D_o = 4'hF;
    case (AL)
      6'h00: D_o = 4'hE;
      6'h01: D_o = {w_chain, SIZE_CODE};
      6'h02: D_o = ~w_prod[7:4];
      6'h03: D_o = ~w_prod[3:0];
      6'h04: D_o = ~ER_FLAGS;
      6'h08: D_o = ~MFG[15:12];
      6'h09: D_o = ~MFG[11:8];
      6'h0A: D_o = ~MFG[7:4];
      6'h0B: D_o = ~MFG[3:0];
      6'h20: D_o = 4'h0;
      6'h21: D_o = 4'h0;
      default: D_o = 4'hF;
    endcase
  end

  for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_ramce
    assign ramce[gi] = r_conf[gi] && (((AH ^ r_base[gi]) & c_MASK) == 8'h00);
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_dt_state <= S_IDLE;
      r_cnt      <= 3'd0;
      DTACK      <= 1'b0;
    end else begin
      case (r_dt_state)
        S_IDLE: begin
          if (!r_as_s2 && (w_ac_acc || (|ramce))) begin
            r_dt_state <= S_WAIT;
            r_cnt      <= c_WAIT;
          end
        end
        S_WAIT: begin
          if (r_as_s2) begin
            r_dt_state <= S_IDLE;
          end else if (r_cnt == 3'd0) begin
            r_dt_state <= S_ACK;
            DTACK      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ACK: begin
          if (r_as_s2) begin
            r_dt_state <= S_IDLE;
            DTACK      <= 1'b0;
          end
        end
        default: begin
          r_dt_state <= S_IDLE;
          DTACK      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zorro_ram_autoconfig_multi.sv
`default_nettype none
// Bench for zorro_ram_autoconfig_multi: two instances (2M/no wait, 512K/wait 3)
// share one bus and are checked against a chain-level reference model.
module tb_zorro_ram_autoconfig_multi;
  logic       CLK = 1'b0, _RST = 1'b0;
  logic [7:0] AH = 8'h00;
  logic [5:0] AL = 6'h00;
  logic [3:0] D_i = 4'h0;
  logic       _AS = 1'b1, _UDS = 1'b1, RW = 1'b1, _configin = 1'b0;
  logic       a_cfgout, a_oe, a_dt, b_cfgout, b_oe, b_dt;
  logic [3:0] a_do, b_do;
  logic [1:0] a_ramce, b_ramce;

  localparam logic [2:0] SZ_A = 3'b110, SZ_B = 3'b100;
  localparam int WAIT_A = 0, WAIT_B = 3;

  zorro_ram_autoconfig_multi #(.NUM_BOARDS(2), .SIZE_CODE(SZ_A), .DTACK_WAIT(WAIT_A)) dut_a (
    .CLK(CLK), ._RST(_RST), .AH(AH), .AL(AL), .D_i(D_i), ._AS(_AS), ._UDS(_UDS), .RW(RW),
    ._configin(_configin), ._configout(a_cfgout), .D_o(a_do), .config_oe(a_oe),
    .DTACK(a_dt), .ramce(a_ramce));

  zorro_ram_autoconfig_multi #(.NUM_BOARDS(2), .SIZE_CODE(SZ_B), .DTACK_WAIT(WAIT_B)) dut_b (
    .CLK(CLK), ._RST(_RST), .AH(AH), .AL(AL), .D_i(D_i), ._AS(_AS), ._UDS(_UDS), .RW(RW),
    ._configin(_configin), ._configout(b_cfgout), .D_o(b_do), .config_oe(b_oe),
    .DTACK(b_dt), .ramce(b_ramce));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;

  // Chain-level model: index of the board on offer, and per-board base/configured flag
  int         m_cur;
  logic [7:0] m_base [2];
  bit         m_conf [2];

  function automatic logic [3:0] rom(input logic [5:0] al, input logic [2:0] sz);
    int off = int'(al) * 2;
    logic [7:0] prod = 8'(8'hEF + m_cur);
    logic [15:0] mfg = 16'h4001;
    case (off)
      'h00: return 4'hE;
      'h02: return {(m_cur != 1), sz};
      'h04: return ~prod[7:4];
      'h06: return ~prod[3:0];
      'h08: return ~4'hC;
      'h10, 'h12, 'h14, 'h16: return ~4'(mfg >> (12 - 2 * (off - 'h10)));
      'h40, 'h42: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  // Board covers 2^(sh+16) bytes, so compare the address above that span
  function automatic logic [1:0] ram_exp(input logic [7:0] ah, input logic [2:0] sz);
    int sh = int'(sz) - 1;
    logic [1:0] r;
    for (int b = 0; b < 2; b++) r[b] = m_conf[b] && ((ah >> sh) == (m_base[b] >> sh));
    return r;
  endfunction

  function automatic bit ac_exp(input logic [7:0] ah);
    return (ah == 8'hE8) && (m_cur < 2) && !_configin;
  endfunction

  task automatic model_reset();
    m_cur = 0;
    for (int b = 0; b < 2; b++) begin m_base[b] = 8'h00; m_conf[b] = 1'b0; end
  endtask

  task automatic do_reset();
    _RST = 1'b0; _AS = 1'b1; _UDS = 1'b1; RW = 1'b1; AH = 8'h00; AL = 6'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK); _RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
  endtask

  task automatic ac_write(input logic [5:0] al, input logic [3:0] d);
    @(negedge CLK);
    AH = 8'hE8; AL = al; D_i = d; RW = 1'b0;
    #1; _AS = 1'b0; _UDS = 1'b0;
    if (ac_exp(8'hE8)) begin
      case (al)
        6'h24: begin m_base[m_cur][7:4] = d; m_conf[m_cur] = 1'b1; m_cur++; end
        6'h25: m_base[m_cur][3:0] = d;
        6'h26: m_cur++;
        default: ;
      endcase
    end
    repeat (10) @(posedge CLK);
    @(negedge CLK); _AS = 1'b1; _UDS = 1'b1; RW = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  // Read cycle: checks data, output enable, DTACK latency and DTACK release
  task automatic bus_access(input logic [7:0] ah, input logic [5:0] al, input string tag);
    bit acc_a = ac_exp(ah) || (|ram_exp(ah, SZ_A));
    bit acc_b = ac_exp(ah) || (|ram_exp(ah, SZ_B));
    int la = 0, lb = 0;
    int la_exp = acc_a ? WAIT_A + 4 : 0;
    int lb_exp = acc_b ? WAIT_B + 4 : 0;
    @(negedge CLK);
    AH = ah; AL = al; RW = 1'b1; _AS = 1'b0;
    #1;
    n_cmp++;
    if (a_oe !== ac_exp(ah)) begin n_fail++; $display("FAIL %s oe_a: got %b want %b", tag, a_oe, ac_exp(ah)); end
    n_cmp++;
    if (b_oe !== ac_exp(ah)) begin n_fail++; $display("FAIL %s oe_b: got %b want %b", tag, b_oe, ac_exp(ah)); end
    if (ac_exp(ah)) begin
      n_cmp++;
      if (a_do !== rom(al, SZ_A)) begin n_fail++; $display("FAIL %s do_a al=%h: got %h want %h", tag, al, a_do, rom(al, SZ_A)); end
      n_cmp++;
      if (b_do !== rom(al, SZ_B)) begin n_fail++; $display("FAIL %s do_b al=%h: got %h want %h", tag, al, b_do, rom(al, SZ_B)); end
    end
    for (int e = 1; e <= 12; e++) begin
      @(posedge CLK); #1;
      if (a_dt && la == 0) la = e;
      if (b_dt && lb == 0) lb = e;
    end
    n_cmp++;
    if (la !== la_exp) begin n_fail++; $display("FAIL %s dtack_lat_a: got %0d want %0d", tag, la, la_exp); end
    n_cmp++;
    if (lb !== lb_exp) begin n_fail++; $display("FAIL %s dtack_lat_b: got %0d want %0d", tag, lb, lb_exp); end
    @(negedge CLK); _AS = 1'b1;
    repeat (4) @(posedge CLK); #1;
    n_cmp++;
    if ({a_dt, b_dt} !== 2'b00) begin n_fail++; $display("FAIL %s dtack_release: got %b want 00", tag, {a_dt, b_dt}); end
  endtask

  task automatic check_ramce(input logic [7:0] ah, input string tag);
    @(negedge CLK);
    _AS = 1'b1; AH = ah;
    #1;
    n_cmp++;
    if (a_ramce !== ram_exp(ah, SZ_A)) begin n_fail++; $display("FAIL %s ramce_a ah=%h: got %b want %b", tag, ah, a_ramce, ram_exp(ah, SZ_A)); end
    n_cmp++;
    if (b_ramce !== ram_exp(ah, SZ_B)) begin n_fail++; $display("FAIL %s ramce_b ah=%h: got %b want %b", tag, ah, b_ramce, ram_exp(ah, SZ_B)); end
  endtask

  task automatic check_cfgout(input string tag);
    logic want = (m_cur == 2) ? 1'b0 : 1'b1;
    #1;
    n_cmp++;
    if ({a_cfgout, b_cfgout} !== {want, want}) begin
      n_fail++; $display("FAIL %s configout: got %b%b want %b", tag, a_cfgout, b_cfgout, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({a_dt, a_ramce, a_oe, a_cfgout, b_dt, b_ramce, b_oe, b_cfgout} !== 10'b0000100001) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0000100001",
                         {a_dt, a_ramce, a_oe, a_cfgout, b_dt, b_ramce, b_oe, b_cfgout});
    end
    bus_access(8'hE8, 6'h00, "rd00");
    bus_access(8'hE8, 6'h01, "rd02");
    bus_access(8'hE8, 6'h02, "rd04");
    bus_access(8'hE8, 6'h08, "rd10");
    check_cfgout("reset");
  endtask

  task automatic test_config();
    ac_write(6'h25, 4'h0);
    ac_write(6'h24, 4'h2);
    check_cfgout("config");
    check_ramce(8'h20, "cfg");
    check_ramce(8'h3F, "cfg");
    check_ramce(8'h40, "cfg");
    check_ramce(8'h1F, "cfg");
    bus_access(8'hE8, 6'h01, "b1_rd02");
    bus_access(8'hE8, 6'h02, "b1_rd04");
    bus_access(8'h21, 6'h00, "ram_rd");
  endtask

  task automatic test_shutup();
    ac_write(6'h26, 4'h0);
    check_cfgout("shutup");
    bus_access(8'hE8, 6'h00, "after_shut");
  endtask

  task automatic test_dtack_abort();
    int seen = 0;
    do_reset();
    @(negedge CLK);
    AH = 8'hE8; AL = 6'h00; RW = 1'b1; _AS = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); _AS = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge CLK); #1;
      if (b_dt) seen = 1;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_b: got dtack=1 want dtack=0"); end
  endtask

  task automatic test_reset_midcycle();
    int e = 0;
    ac_write(6'h25, 4'h0);
    ac_write(6'h24, 4'h2);
    @(negedge CLK);
    AH = 8'h20; AL = 6'h00; RW = 1'b1; _AS = 1'b0;
    while (!a_dt && e < 12) begin @(posedge CLK); #1; e++; end
    n_cmp++;
    if (a_dt !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_dtack: got %b want 1", a_dt); end
    #2; _RST = 1'b0;
    #1;
    n_cmp++;
    if ({a_dt, a_ramce, a_cfgout, b_dt, b_ramce, b_cfgout} !== 8'b00010001) begin
      n_fail++; $display("FAIL midreset_outputs: got %b want 00010001",
                         {a_dt, a_ramce, a_cfgout, b_dt, b_ramce, b_cfgout});
    end
    _AS = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); _RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    bus_access(8'hE8, 6'h00, "post_reset_rd00");
    bus_access(8'hE8, 6'h02, "post_reset_rd04");
  endtask

  task automatic test_small_size();
    do_reset();
    ac_write(6'h25, 4'h8);
    ac_write(6'h24, 4'h3);
    for (int a = 8'h30; a <= 8'h47; a += 3) check_ramce(8'(a), "size");
    check_ramce(8'h38, "size");
    check_ramce(8'h3F, "size");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 1) == 1) ac_write(6'($urandom_range(0, 23)), 4'($urandom));
        ac_write(6'h25, 4'($urandom));
        bus_access(8'hE8, 6'($urandom_range(0, 35)), "rand_rd");
        if ($urandom_range(0, 2) != 0) ac_write(6'h24, 4'($urandom));
        else ac_write(6'h26, 4'($urandom));
      end
      check_cfgout("rand");
      for (int k = 0; k < 6; k++) check_ramce(8'($urandom), "rand");
      bus_access(m_conf[0] ? m_base[0] : 8'($urandom), 6'h00, "rand_acc");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_config();
    test_shutup();
    test_dtack_abort();
    test_reset_midcycle();
    test_small_size();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
